// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the fetch-side branch predictor
//
// Purpose : counter-state encoding and BTB entry layout shared by the
//           predictor top level and its saturating-counter helper.
// Ports   : none (package).
package riscv_pkg;

    // Widest tag the entry struct can carry; the top level zero-extends its
    // TAG_W-bit tag into this field so the struct stays parameter-free.
    localparam int BP_TAG_W_MAX = 32;
    localparam int BP_TGT_W     = 64;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W_MAX-1:0] tag;
        logic [BP_TGT_W-1:0]     target;
        bp_ctr_e                 ctr;
    } bp_btb_entry_t;

endpackage

// File: rtl/riscv_bp_sat_ctr.sv
// rtl/riscv_bp_sat_ctr.sv - 2-bit saturating counter next-state function
//
// Purpose : combinational next state of one BTB direction counter.
// Ports   : ctr      - current counter state
//           taken    - resolved outcome (1 = taken)
//           force_st - unconditional jump, jump straight to strongly taken
//           ctr_next - next counter state
module riscv_bp_sat_ctr
    import riscv_pkg::*;
(
    input  bp_ctr_e ctr,
    input  logic    taken,
    input  logic    force_st,
    output bp_ctr_e ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (force_st) begin
            ctr_next = BP_ST;
        end else if (taken) begin
            if (ctr != BP_ST) begin
                ctr_next = bp_ctr_e'(ctr + 2'd1);
            end
        end else begin
            if (ctr != BP_SNT) begin
                ctr_next = bp_ctr_e'(ctr - 2'd1);
            end
        end
    end

endmodule

// File: rtl/riscv_branch_predictor.sv
// rtl/riscv_branch_predictor.sv - direct-mapped BTB with 2-bit direction counters
//
// Purpose : same-cycle taken/target prediction for the fetch PC, trained by
//           resolved control transfers from execute; counts updates and
//           mispredictions.
// Ports   : i_riscv_clk / i_riscv_rst          - clock, async active-high reset
//           i_riscv_bp_fetch_pc                - PC being fetched
//           o_riscv_bp_pred_taken/_pred_target - prediction for fetch PC
//           i_riscv_bp_upd_*                   - resolved branch/jump feedback
//           o_riscv_bp_mispredict              - mispredict flag for current update
//           o_riscv_bp_upd_cnt / _mispred_cnt  - saturating statistics
module riscv_branch_predictor
    import riscv_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 12
) (
    input  logic        i_riscv_clk,
    input  logic        i_riscv_rst,
    input  logic [63:0] i_riscv_bp_fetch_pc,
    output logic        o_riscv_bp_pred_taken,
    output logic [63:0] o_riscv_bp_pred_target,
    input  logic        i_riscv_bp_upd_valid,
    input  logic [63:0] i_riscv_bp_upd_pc,
    input  logic        i_riscv_bp_upd_taken,
    input  logic        i_riscv_bp_upd_uncond,
    input  logic [63:0] i_riscv_bp_upd_target,
    input  logic        i_riscv_bp_upd_pred_taken,
    input  logic [63:0] i_riscv_bp_upd_pred_target,
    output logic        o_riscv_bp_mispredict,
    output logic [31:0] o_riscv_bp_upd_cnt,
    output logic [31:0] o_riscv_bp_mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_btb_entry_t btb_q [ENTRIES];
    bp_btb_entry_t btb_d [ENTRIES];
    logic [31:0]   upd_cnt_q, upd_cnt_d;
    logic [31:0]   mispred_cnt_q, mispred_cnt_d;

    // Index skips bit 0: compressed instructions sit on 2-byte boundaries.
    logic [IDX_W-1:0]        fetch_idx, upd_idx;
    logic [BP_TAG_W_MAX-1:0] fetch_tag, upd_tag;
    bp_btb_entry_t           fetch_entry, upd_entry;
    logic                    fetch_hit, upd_hit;
    bp_ctr_e                 upd_ctr_next;
    logic                    mispredict;

    assign fetch_idx = i_riscv_bp_fetch_pc[IDX_W:1];
    assign upd_idx   = i_riscv_bp_upd_pc[IDX_W:1];
    assign fetch_tag = BP_TAG_W_MAX'(i_riscv_bp_fetch_pc[IDX_W+TAG_W:IDX_W+1]);
    assign upd_tag   = BP_TAG_W_MAX'(i_riscv_bp_upd_pc[IDX_W+TAG_W:IDX_W+1]);

    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_riscv_bp_fetch_pc[63:IDX_W+TAG_W+1], i_riscv_bp_fetch_pc[0],
                              i_riscv_bp_upd_pc[63:IDX_W+TAG_W+1], i_riscv_bp_upd_pc[0]};

    // Lookup reads registered state only, so an update in the same cycle is
    // not seen until the following cycle.
    always_comb begin
        fetch_entry = btb_q[fetch_idx];
        fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
        upd_entry   = btb_q[upd_idx];
        upd_hit     = upd_entry.valid && (upd_entry.tag == upd_tag);
    end

    assign o_riscv_bp_pred_taken  = fetch_hit && fetch_entry.ctr[1];
    assign o_riscv_bp_pred_target = fetch_hit ? fetch_entry.target : 64'd0;

    riscv_bp_sat_ctr u_sat_ctr (
        .ctr      (upd_entry.ctr),
        .taken    (i_riscv_bp_upd_taken),
        .force_st (i_riscv_bp_upd_uncond),
        .ctr_next (upd_ctr_next)
    );

    // A correct direction with a wrong target still costs a redirect.
    assign mispredict = i_riscv_bp_upd_valid &&
                        ((i_riscv_bp_upd_taken != i_riscv_bp_upd_pred_taken) ||
                         (i_riscv_bp_upd_taken && i_riscv_bp_upd_pred_taken &&
                          (i_riscv_bp_upd_target != i_riscv_bp_upd_pred_target)));
    assign o_riscv_bp_mispredict = mispredict;

    always_comb begin
        btb_d = btb_q;
        if (i_riscv_bp_upd_valid) begin
            if (upd_hit) begin
                btb_d[upd_idx].ctr = upd_ctr_next;
                if (i_riscv_bp_upd_taken) begin
                    btb_d[upd_idx].target = i_riscv_bp_upd_target;
                end
            end else if (i_riscv_bp_upd_taken) begin
                // Allocation evicts whatever aliased entry occupies the slot.
                btb_d[upd_idx].valid  = 1'b1;
                btb_d[upd_idx].tag    = upd_tag;
                btb_d[upd_idx].target = i_riscv_bp_upd_target;
                btb_d[upd_idx].ctr    = i_riscv_bp_upd_uncond ? BP_ST : BP_WT;
            end
        end
    end

    always_comb begin
        upd_cnt_d     = upd_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (i_riscv_bp_upd_valid && (upd_cnt_q != 32'hFFFF_FFFF)) begin
            upd_cnt_d = upd_cnt_q + 32'd1;
        end
        if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
        if (i_riscv_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_WNT};
            end
            upd_cnt_q     <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= btb_d[i];
            end
            upd_cnt_q     <= upd_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_riscv_bp_upd_cnt     = upd_cnt_q;
    assign o_riscv_bp_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// tb/tb_riscv_branch_predictor.sv - self-checking bench for riscv_branch_predictor
module tb_riscv_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 12;
    localparam int IDX_W   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fetch_pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic        upd_uncond;
    logic [63:0] upd_target;
    logic        upd_pred_taken;
    logic [63:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] upd_cnt;
    logic [31:0] mispred_cnt;

    always #5 clk = ~clk;

    riscv_branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .i_riscv_clk                (clk),
        .i_riscv_rst                (rst),
        .i_riscv_bp_fetch_pc        (fetch_pc),
        .o_riscv_bp_pred_taken      (pred_taken),
        .o_riscv_bp_pred_target     (pred_target),
        .i_riscv_bp_upd_valid       (upd_valid),
        .i_riscv_bp_upd_pc          (upd_pc),
        .i_riscv_bp_upd_taken       (upd_taken),
        .i_riscv_bp_upd_uncond      (upd_uncond),
        .i_riscv_bp_upd_target      (upd_target),
        .i_riscv_bp_upd_pred_taken  (upd_pred_taken),
        .i_riscv_bp_upd_pred_target (upd_pred_target),
        .o_riscv_bp_mispredict      (mispredict),
        .o_riscv_bp_upd_cnt         (upd_cnt),
        .o_riscv_bp_mispred_cnt     (mispred_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain arrays, counter kept as an integer 0..3.
    bit          m_valid [ENTRIES];
    longint      m_tag   [ENTRIES];
    logic [63:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_upd;
    longint      m_mis;
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    function automatic int m_idx(input logic [63:0] pc);
        return int'((pc >> 1) % ENTRIES);
    endfunction

    function automatic longint m_tagof(input logic [63:0] pc);
        return longint'((pc >> (IDX_W + 1)) % (64'd1 << TAG_W));
    endfunction

    function automatic bit m_hit(input logic [63:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_pred(input logic [63:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [63:0] m_ptgt(input logic [63:0] pc);
        return m_hit(pc) ? m_tgt[m_idx(pc)] : 64'd0;
    endfunction

    function automatic bit m_misp();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 64'd0;
            m_ctr[i]   = 1;
        end
        m_upd = 0;
        m_mis = 0;
    endtask

    task automatic m_update();
        int i;
        if (!upd_valid) return;
        i = m_idx(upd_pc);
        if (m_misp() && m_mis < CNT_MAX) m_mis++;
        if (m_upd < CNT_MAX) m_upd++;
        if (m_hit(upd_pc)) begin
            if (upd_uncond)     m_ctr[i] = 3;
            else if (upd_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            if (upd_taken) m_tgt[i] = upd_target;
        end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tagof(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[i]   = upd_uncond ? 3 : 2;
        end
    endtask

    task automatic drive_upd(input logic [63:0] pc, input bit tk, input bit un,
                             input logic [63:0] tg, input bit ptk, input logic [63:0] ptg);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_uncond      = un;
        upd_target      = tg;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
    endtask

    task automatic idle();
        upd_valid = 1'b0;
    endtask

    // Compare every output to the model, then clock one edge and train the model.
    task automatic cyc();
        #1;
        check("pred_taken",  {63'd0, pred_taken}, {63'd0, m_pred(fetch_pc)});
        check("pred_target", pred_target, m_ptgt(fetch_pc));
        check("mispredict",  {63'd0, mispredict}, {63'd0, m_misp()});
        check("upd_cnt",     {32'd0, upd_cnt}, m_upd);
        check("mispred_cnt", {32'd0, mispred_cnt}, m_mis);
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] pc;
        rst = 1'b1;
        fetch_pc = 64'h8000_0010;
        idle();
        upd_pc = '0; upd_taken = 0; upd_uncond = 0; upd_target = '0;
        upd_pred_taken = 0; upd_pred_target = '0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_pred_taken",  {63'd0, pred_taken}, 64'd0);
        check("rst_pred_target", pred_target, 64'd0);
        check("rst_upd_cnt",     {32'd0, upd_cnt}, 64'd0);
        check("rst_mis_cnt",     {32'd0, mispred_cnt}, 64'd0);
        cyc();

        // First allocation is a mispredict
        drive_upd(64'h8000_0010, 1, 0, 64'h8000_0100, 0, 64'd0);
        #1 check("s2_misp", {63'd0, mispredict}, 64'd1);
        cyc();
        idle();
        #1;
        check("s2_upd_cnt",  {32'd0, upd_cnt}, 64'd1);
        check("s2_mis_cnt",  {32'd0, mispred_cnt}, 64'd1);
        check("s2_pred",     {63'd0, pred_taken}, 64'd1);
        check("s2_target",   pred_target, 64'h8000_0100);

        // Training 10 -> 01 -> 00 -> 00, then two takens to predict again
        drive_upd(64'h8000_0010, 0, 0, 64'd0, 1, 64'h8000_0100);
        cyc();
        #1 check("s3_pred_after_nt1", {63'd0, pred_taken}, 64'd0);
        drive_upd(64'h8000_0010, 0, 0, 64'd0, 0, 64'd0);
        cyc();
        cyc();
        drive_upd(64'h8000_0010, 1, 0, 64'h8000_0100, 0, 64'd0);
        cyc();
        #1 check("s3_pred_after_t1", {63'd0, pred_taken}, 64'd0);
        cyc();
        #1 check("s3_pred_after_t2", {63'd0, pred_taken}, 64'd1);

        // Aliasing on index 8
        drive_upd(64'h8000_0090, 1, 0, 64'h8000_0300, 0, 64'd0);
        cyc();
        idle();
        #1 check("s4_old_pc", {63'd0, pred_taken}, 64'd0);
        cyc();
        fetch_pc = 64'h8000_0090;
        #1 check("s4_new_pc", {63'd0, pred_taken}, 64'd1);
        drive_upd(64'h8000_0010, 0, 0, 64'd0, 0, 64'd0);
        cyc();
        idle();
        #1 check("s4_nt_miss_keep", pred_target, 64'h8000_0300);
        cyc();

        // Same-cycle collision, then JAL forcing strongly taken
        fetch_pc = 64'h8000_0040;
        drive_upd(64'h8000_0040, 1, 0, 64'h8000_0100, 0, 64'd0);
        #1 check("s5_same_cycle", {63'd0, pred_taken}, 64'd0);
        cyc();
        idle();
        #1 check("s5_next_cycle", {63'd0, pred_taken}, 64'd1);
        cyc();
        fetch_pc = 64'h8000_0060;
        drive_upd(64'h8000_0060, 1, 1, 64'h8000_1000, 0, 64'd0);
        cyc();
        drive_upd(64'h8000_0060, 0, 0, 64'd0, 1, 64'h8000_1000);
        cyc();
        idle();
        #1 check("s5_jal_st", {63'd0, pred_taken}, 64'd1);
        cyc();

        // Right direction, wrong target
        fetch_pc = 64'h8000_0040;
        drive_upd(64'h8000_0040, 1, 0, 64'h8000_0200, 1, 64'h8000_0100);
        #1 check("s6_tgt_misp", {63'd0, mispredict}, 64'd1);
        cyc();
        idle();
        #1 check("s6_tgt_upd", pred_target, 64'h8000_0200);

        // Counter saturation from a preloaded value
        dut.upd_cnt_q     = 32'hFFFF_FFFE;
        dut.mispred_cnt_q = 32'hFFFF_FFFE;
        m_upd = 64'hFFFF_FFFE;
        m_mis = 64'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            drive_upd(64'h8000_0040, 0, 0, 64'd0, 1, 64'h8000_0200);
            cyc();
        end
        idle();
        #1;
        check("sat_upd_cnt", {32'd0, upd_cnt}, 64'hFFFF_FFFF);
        check("sat_mis_cnt", {32'd0, mispred_cnt}, 64'hFFFF_FFFF);

        // Asynchronous reset mid-update with a trained fetch PC
        fetch_pc = 64'h8000_0060;
        drive_upd(64'h8000_0060, 0, 0, 64'd0, 1, 64'h8000_1000);
        #1 check("pre_rst_pred", {63'd0, pred_taken}, 64'd1);
        #1 rst = 1'b1;
        #1;
        m_reset();
        check("arst_pred",   {63'd0, pred_taken}, 64'd0);
        check("arst_target", pred_target, 64'd0);
        check("arst_upd",    {32'd0, upd_cnt}, 64'd0);
        check("arst_mis",    {32'd0, mispred_cnt}, 64'd0);
        check("arst_misp",   {63'd0, mispredict}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Randomized traffic over a small aliasing PC pool
        for (int n = 0; n < 600; n++) begin
            fetch_pc = 64'h8000_0000 | (64'($urandom_range(0, 7)) << 1)
                                     | (64'($urandom_range(0, 2)) << 7);
            if ($urandom_range(0, 3) != 0) begin
                pc = 64'h8000_0000 | (64'($urandom_range(0, 7)) << 1)
                                   | (64'($urandom_range(0, 2)) << 7);
                upd_valid  = 1'b1;
                upd_pc     = pc;
                upd_uncond = ($urandom_range(0, 5) == 0);
                upd_taken  = upd_uncond ? 1'b1 : 1'($urandom_range(0, 1));
                upd_target = 64'h8000_4000 + 64'($urandom_range(0, 3)) * 64'h40;
                if ($urandom_range(0, 1) != 0) begin
                    upd_pred_taken  = m_pred(pc);
                    upd_pred_target = m_ptgt(pc);
                end else begin
                    upd_pred_taken  = 1'($urandom_range(0, 1));
                    upd_pred_target = 64'h8000_4000 + 64'($urandom_range(0, 3)) * 64'h40;
                end
            end else begin
                idle();
                upd_pc     = 64'($urandom);
                upd_taken  = 1'($urandom_range(0, 1));
                upd_pred_taken = ~upd_taken;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
